// File: rtl/operand_fetch.sv
// Operand fetch: drives register-file reads, tracks pending writes, issues registered operand
// packets to execute. Define OPFETCH_BYPASS_EN to forward writeback data to a stalled reader.
module operand_fetch #(
    parameter int unsigned XLEN   = 32,
    parameter int unsigned REG_AW = 5
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              id_valid,
    output logic              id_ready,
    input  logic [REG_AW-1:0] id_rs1,
    input  logic [REG_AW-1:0] id_rs2,
    input  logic              id_rs1_en,
    input  logic              id_rs2_en,
    input  logic [REG_AW-1:0] id_rd,
    input  logic              id_rd_en,
    input  logic [XLEN-1:0]   id_imm,
    output logic [REG_AW-1:0] src_rs1,
    output logic [REG_AW-1:0] src_rs2,
    output logic              rs1_valid,
    output logic              rs2_valid,
    input  logic [XLEN-1:0]   rs1,
    input  logic [XLEN-1:0]   rs2,
    input  logic              wb_valid,
    input  logic [REG_AW-1:0] wb_rd,
    input  logic [XLEN-1:0]   wb_data,
    output logic              ex_valid,
    input  logic              ex_ready,
    output logic [XLEN-1:0]   ex_op1,
    output logic [XLEN-1:0]   ex_op2,
    output logic [XLEN-1:0]   ex_imm,
    output logic [REG_AW-1:0] ex_rd,
    output logic              ex_rd_en
);

    localparam int unsigned NumRegs = 1 << REG_AW;

    logic [NumRegs-1:0] busy_q, busy_d;
    logic               ex_valid_q, ex_valid_d;
    logic [XLEN-1:0]    ex_op1_q, ex_op1_d;
    logic [XLEN-1:0]    ex_op2_q, ex_op2_d;
    logic [XLEN-1:0]    ex_imm_q, ex_imm_d;
    logic [REG_AW-1:0]  ex_rd_q, ex_rd_d;
    logic               ex_rd_en_q, ex_rd_en_d;

    logic rs1_used, rs2_used;
    logic byp_rs1, byp_rs2;
    logic hazard_rs1, hazard_rs2, hazard;
    logic issue;
    logic [XLEN-1:0] op1, op2;

    assign src_rs1   = id_rs1;
    assign src_rs2   = id_rs2;
    assign rs1_valid = id_valid & id_rs1_en;
    assign rs2_valid = id_valid & id_rs2_en;

    assign rs1_used = id_rs1_en && (id_rs1 != '0);
    assign rs2_used = id_rs2_en && (id_rs2 != '0);

`ifdef OPFETCH_BYPASS_EN
    assign byp_rs1 = wb_valid && (wb_rd != '0) && (wb_rd == id_rs1);
    assign byp_rs2 = wb_valid && (wb_rd != '0) && (wb_rd == id_rs2);
`else
    assign byp_rs1 = 1'b0;
    assign byp_rs2 = 1'b0;
`endif

    assign hazard_rs1 = rs1_used && busy_q[id_rs1] && !byp_rs1;
    assign hazard_rs2 = rs2_used && busy_q[id_rs2] && !byp_rs2;
    assign hazard     = hazard_rs1 | hazard_rs2;

    assign id_ready = (!ex_valid_q | ex_ready) & !hazard;
    assign issue    = id_valid & id_ready;

    always_comb begin
        op1 = '0;
        op2 = '0;
        if (rs1_used) op1 = byp_rs1 ? wb_data : rs1;
        if (rs2_used) op2 = byp_rs2 ? wb_data : rs2;
    end

    always_comb begin
        busy_d = busy_q;
        if (wb_valid && (wb_rd != '0)) busy_d[wb_rd] = 1'b0;
        // Set after clear so a same-cycle new writer keeps the register busy.
        if (issue && id_rd_en && (id_rd != '0)) busy_d[id_rd] = 1'b1;
        busy_d[0] = 1'b0;
    end

    always_comb begin
        ex_valid_d = ex_valid_q;
        ex_op1_d   = ex_op1_q;
        ex_op2_d   = ex_op2_q;
        ex_imm_d   = ex_imm_q;
        ex_rd_d    = ex_rd_q;
        ex_rd_en_d = ex_rd_en_q;
        if (issue) begin
            ex_valid_d = 1'b1;
            ex_op1_d   = op1;
            ex_op2_d   = op2;
            ex_imm_d   = id_imm;
            ex_rd_d    = id_rd;
            ex_rd_en_d = id_rd_en;
        end else if (ex_ready) begin
            ex_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            busy_q     <= '0;
            ex_valid_q <= 1'b0;
            ex_op1_q   <= '0;
            ex_op2_q   <= '0;
            ex_imm_q   <= '0;
            ex_rd_q    <= '0;
            ex_rd_en_q <= 1'b0;
        end else begin
            busy_q     <= busy_d;
            ex_valid_q <= ex_valid_d;
            ex_op1_q   <= ex_op1_d;
            ex_op2_q   <= ex_op2_d;
            ex_imm_q   <= ex_imm_d;
            ex_rd_q    <= ex_rd_d;
            ex_rd_en_q <= ex_rd_en_d;
        end
    end

    assign ex_valid = ex_valid_q;
    assign ex_op1   = ex_op1_q;
    assign ex_op2   = ex_op2_q;
    assign ex_imm   = ex_imm_q;
    assign ex_rd    = ex_rd_q;
    assign ex_rd_en = ex_rd_en_q;

endmodule

// File: tb/tb_operand_fetch.sv
// Scoreboard bench for operand_fetch: a register-file model answers reads, the driver queues
// expected execute packets at issue, and a monitor pops and compares on each accepted packet.
module tb_operand_fetch;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        id_valid = 1'b0, id_ready;
    logic [4:0]  id_rs1 = '0, id_rs2 = '0, id_rd = '0;
    logic        id_rs1_en = 1'b0, id_rs2_en = 1'b0, id_rd_en = 1'b0;
    logic [31:0] id_imm = '0;
    logic [4:0]  src_rs1, src_rs2;
    logic        rs1_valid, rs2_valid;
    logic [31:0] rs1, rs2;
    logic        wb_valid = 1'b0;
    logic [4:0]  wb_rd = '0;
    logic [31:0] wb_data = '0;
    logic        ex_valid, ex_ready = 1'b1;
    logic [31:0] ex_op1, ex_op2, ex_imm;
    logic [4:0]  ex_rd;
    logic        ex_rd_en;

    typedef struct packed {
        logic [31:0] op1;
        logic [31:0] op2;
        logic [31:0] imm;
        logic [4:0]  rd;
        logic        rd_en;
    } pkt_t;

    pkt_t exp_q[$];
    int   errors = 0;
    int   checks = 0;

    // x0 deliberately returns garbage so the block must zero it.
    logic [31:0] rf [32];
    assign rs1 = rf[src_rs1];
    assign rs2 = rf[src_rs2];

    always @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < 32; i++) rf[i] <= 32'(i) << 8;
            rf[0] <= 32'h1234;
            rf[1] <= 32'hFFFF_FFFD;
            rf[2] <= 32'd3;
        end else if (wb_valid && wb_rd != 5'd0) begin
            rf[wb_rd] <= wb_data;
        end
    end

    always #5 clk = ~clk;

    operand_fetch #(.XLEN(32), .REG_AW(5)) dut (
        .clk(clk), .reset(reset),
        .id_valid(id_valid), .id_ready(id_ready),
        .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rs1_en(id_rs1_en), .id_rs2_en(id_rs2_en),
        .id_rd(id_rd), .id_rd_en(id_rd_en), .id_imm(id_imm),
        .src_rs1(src_rs1), .src_rs2(src_rs2), .rs1_valid(rs1_valid), .rs2_valid(rs2_valid),
        .rs1(rs1), .rs2(rs2),
        .wb_valid(wb_valid), .wb_rd(wb_rd), .wb_data(wb_data),
        .ex_valid(ex_valid), .ex_ready(ex_ready),
        .ex_op1(ex_op1), .ex_op2(ex_op2), .ex_imm(ex_imm), .ex_rd(ex_rd), .ex_rd_en(ex_rd_en)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic set_id(input logic v, input logic [4:0] r1, input logic e1,
                          input logic [4:0] r2, input logic e2,
                          input logic [4:0] rd, input logic rde, input logic [31:0] imm);
        id_valid = v; id_rs1 = r1; id_rs1_en = e1; id_rs2 = r2; id_rs2_en = e2;
        id_rd = rd; id_rd_en = rde; id_imm = imm;
    endtask

    task automatic set_wb(input logic v, input logic [4:0] rd, input logic [31:0] d);
        wb_valid = v; wb_rd = rd; wb_data = d;
    endtask

    task automatic push(input logic [31:0] o1, input logic [31:0] o2, input logic [31:0] imm,
                        input logic [4:0] rd, input logic rde);
        pkt_t p;
        p.op1 = o1; p.op2 = o2; p.imm = imm; p.rd = rd; p.rd_en = rde;
        exp_q.push_back(p);
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // Monitor: one packet leaves per cycle with ex_valid & ex_ready.
    always @(negedge clk) begin
        if (!reset && ex_valid && ex_ready) begin
            if (exp_q.size() == 0) begin
                check("unexpected_packet", 32'd1, 32'd0);
            end else begin
                pkt_t e;
                e = exp_q.pop_front();
                check("ex_op1", ex_op1, e.op1);
                check("ex_op2", ex_op2, e.op2);
                check("ex_imm", ex_imm, e.imm);
                check("ex_rd", {27'd0, ex_rd}, {27'd0, e.rd});
                check("ex_rd_en", {31'd0, ex_rd_en}, {31'd0, e.rd_en});
            end
        end
    end

    initial begin
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_ex_valid", {31'd0, ex_valid}, 32'd0);
        check("rst_ex_op1", ex_op1, 32'd0);
        check("rst_ex_op2", ex_op2, 32'd0);
        check("rst_ex_imm", ex_imm, 32'd0);
        check("rst_ex_rd", {27'd0, ex_rd}, 32'd0);
        check("rst_ex_rd_en", {31'd0, ex_rd_en}, 32'd0);
        tick;
        reset = 1'b0;

        // Basic issue, rfile returns -3 and 3.
        set_id(1, 5'd1, 1, 5'd2, 1, 5'd4, 0, 32'h11);
        @(negedge clk);
        check("t1_ready", {31'd0, id_ready}, 32'd1);
        check("t1_rs1_valid", {31'd0, rs1_valid}, 32'd1);
        check("t1_src_rs2", {27'd0, src_rs2}, 32'd2);
        push(32'hFFFF_FFFD, 32'd3, 32'h11, 5'd4, 0);
        tick;

        // x0 reads as zero; writeback to x0 is ignored.
        set_id(1, 5'd0, 1, 5'd0, 0, 5'd0, 0, 32'h22);
        set_wb(1, 5'd0, 32'hDEAD);
        @(negedge clk);
        check("t1_latency_ex_valid", {31'd0, ex_valid}, 32'd1);
        check("t2_ready", {31'd0, id_ready}, 32'd1);
        push(32'd0, 32'd0, 32'h22, 5'd0, 0);
        tick;

        // Writer to x3.
        set_id(1, 5'd1, 1, 5'd0, 0, 5'd3, 1, 32'h33);
        set_wb(0, 5'd0, 32'd0);
        @(negedge clk);
        check("t3_ready", {31'd0, id_ready}, 32'd1);
        push(32'hFFFF_FFFD, 32'd0, 32'h33, 5'd3, 1);
        tick;

        // Reader of x3 stalls until writeback.
        set_id(1, 5'd3, 1, 5'd2, 1, 5'd6, 0, 32'h44);
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            check("raw_stall", {31'd0, id_ready}, 32'd0);
            tick;
        end
        set_wb(1, 5'd3, 32'd2);
        @(negedge clk);
`ifdef OPFETCH_BYPASS_EN
        check("raw_bypass_ready", {31'd0, id_ready}, 32'd1);
        push(32'd2, 32'd3, 32'h44, 5'd6, 0);
        tick;
        set_wb(0, 5'd0, 32'd0);
`else
        check("raw_wb_cycle_stall", {31'd0, id_ready}, 32'd0);
        tick;
        set_wb(0, 5'd0, 32'd0);
        @(negedge clk);
        check("raw_after_wb_ready", {31'd0, id_ready}, 32'd1);
        push(32'd2, 32'd3, 32'h44, 5'd6, 0);
        tick;
`endif
        set_id(0, 5'd0, 0, 5'd0, 0, 5'd0, 0, 32'd0);
        tick;

        // Backpressure: packet A held three cycles, then B issues back to back.
        ex_ready = 1'b0;
        set_id(1, 5'd2, 1, 5'd1, 1, 5'd8, 0, 32'h55);
        @(negedge clk);
        check("bp_a_ready", {31'd0, id_ready}, 32'd1);
        push(32'd3, 32'hFFFF_FFFD, 32'h55, 5'd8, 0);
        tick;
        set_id(1, 5'd1, 1, 5'd2, 1, 5'd9, 0, 32'h66);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("bp_ready_low", {31'd0, id_ready}, 32'd0);
            check("bp_hold_valid", {31'd0, ex_valid}, 32'd1);
            check("bp_hold_op1", ex_op1, 32'd3);
            check("bp_hold_imm", ex_imm, 32'h55);
            tick;
        end
        ex_ready = 1'b1;
        @(negedge clk);
        check("bp_b_ready", {31'd0, id_ready}, 32'd1);
        push(32'hFFFF_FFFD, 32'd3, 32'h66, 5'd9, 0);
        tick;

        // Issue rd=5 while x5 writes back: set wins, later reader stalls.
        set_id(1, 5'd2, 1, 5'd0, 0, 5'd5, 1, 32'h77);
        set_wb(1, 5'd5, 32'h99);
        @(negedge clk);
        check("no_bubble_ex_valid", {31'd0, ex_valid}, 32'd1);
        check("sw_ready", {31'd0, id_ready}, 32'd1);
        push(32'd3, 32'd0, 32'h77, 5'd5, 1);
        tick;
        set_id(1, 5'd5, 1, 5'd0, 0, 5'd0, 0, 32'h78);
        set_wb(0, 5'd0, 32'd0);
        @(negedge clk);
        check("set_wins_stall", {31'd0, id_ready}, 32'd0);
        tick;
        set_wb(1, 5'd5, 32'hAB);
        @(negedge clk);
`ifdef OPFETCH_BYPASS_EN
        check("sw_bypass_ready", {31'd0, id_ready}, 32'd1);
        push(32'hAB, 32'd0, 32'h78, 5'd0, 0);
        tick;
        set_wb(0, 5'd0, 32'd0);
`else
        check("sw_wb_cycle_stall", {31'd0, id_ready}, 32'd0);
        tick;
        set_wb(0, 5'd0, 32'd0);
        @(negedge clk);
        check("sw_after_wb_ready", {31'd0, id_ready}, 32'd1);
        push(32'hAB, 32'd0, 32'h78, 5'd0, 0);
        tick;
`endif
        set_id(0, 5'd0, 0, 5'd0, 0, 5'd0, 0, 32'd0);
        tick;

        // Reset with a held packet and busy x7.
        ex_ready = 1'b0;
        set_id(1, 5'd1, 1, 5'd0, 0, 5'd7, 1, 32'h88);
        @(negedge clk);
        check("rs_issue_ready", {31'd0, id_ready}, 32'd1);
        push(32'hFFFF_FFFD, 32'd0, 32'h88, 5'd7, 1);
        tick;
        set_id(0, 5'd0, 0, 5'd0, 0, 5'd0, 0, 32'd0);
        @(negedge clk);
        check("rs_pre_ex_valid", {31'd0, ex_valid}, 32'd1);
        #2;
        reset = 1'b1;
        void'(exp_q.pop_back());
        #1;
        check("rs_async_ex_valid", {31'd0, ex_valid}, 32'd0);
        check("rs_async_ex_op1", ex_op1, 32'd0);
        check("rs_async_ex_imm", ex_imm, 32'd0);
        check("rs_async_ex_rd", {27'd0, ex_rd}, 32'd0);
        check("rs_async_ex_rd_en", {31'd0, ex_rd_en}, 32'd0);
        tick;
        reset = 1'b0;
        ex_ready = 1'b1;
        set_id(1, 5'd7, 1, 5'd0, 0, 5'd0, 0, 32'h99);
        @(negedge clk);
        check("rs_busy_cleared_ready", {31'd0, id_ready}, 32'd1);
        push(32'h700, 32'd0, 32'h99, 5'd0, 0);
        tick;
        set_id(0, 5'd0, 0, 5'd0, 0, 5'd0, 0, 32'd0);
        @(negedge clk);
        tick;
        check("queue_drained", exp_q.size(), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
